// File: rtl/instr_dispatch_bridge_pkg.sv
// Shared definitions for the matrix coprocessor front-end: instruction field
// positions, opcode values and the dispatch FSM state type.
package instr_dispatch_bridge_pkg;

    localparam int unsigned DATA_MSB  = 26;
    localparam int unsigned DATA_LSB  = 11;
    localparam int unsigned OPC_MSB   = 10;
    localparam int unsigned OPC_LSB   = 7;
    localparam int unsigned MSIZE_MSB = 6;
    localparam int unsigned MSIZE_LSB = 5;
    localparam int unsigned POS_MSB   = 4;
    localparam int unsigned POS_LSB   = 1;
    localparam int unsigned START_BIT = 0;

    localparam logic [3:0] OPC_SOMA          = 4'b0000;
    localparam logic [3:0] OPC_SUBTRACAO     = 4'b0001;
    localparam logic [3:0] OPC_MULT_MATRIZ   = 4'b0010;
    localparam logic [3:0] OPC_MULT_ESCALAR  = 4'b0011;
    localparam logic [3:0] OPC_TRANSPOSTA    = 4'b0100;
    localparam logic [3:0] OPC_OPOSTA        = 4'b0101;
    localparam logic [3:0] OPC_DETERMINANTE  = 4'b0110;
    localparam logic [3:0] OPC_STORE_MATRIX1 = 4'b0111;
    localparam logic [3:0] OPC_STORE_MATRIX2 = 4'b1000;
    localparam logic [3:0] OPC_LOAD_MATRIXR  = 4'b1001;

    localparam logic [3:0] MAX_OPCODE     = OPC_LOAD_MATRIXR;
    // Arithmetic opcodes are the only ones whose overflow output is meaningful.
    localparam logic [3:0] OVF_OPCODE_MAX = OPC_DETERMINANTE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } disp_state_t;

    function automatic logic [3:0] instr_opcode(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_dispatch_bridge_fifo.sv
// Show-ahead synchronous FIFO for queued instruction words; a push while full
// is accepted only when a pop happens in the same cycle.
module instr_dispatch_bridge_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_dispatch_bridge.sv
// HPS-to-control-unit instruction bridge: queues PIO words, issues them one at
// a time with a single-cycle start pulse, and captures results and sticky flags.
module instr_dispatch_bridge
    import instr_dispatch_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CU_LATENCY = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] hps_instr,
    input  logic        hps_wr,
    input  logic        hps_clr,
    output logic [31:0] hps_result,
    output logic [7:0]  hps_status,
    output logic [31:0] cu_instruction,
    input  logic        cu_ready,
    input  logic [31:0] cu_data,
    input  logic        cu_overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WW = $clog2(CU_LATENCY + 1);

    disp_state_t   state;
    logic          wr_prev;
    logic          ready_prev;
    logic          wr_rise;
    logic          ready_rise;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [WW-1:0] wait_cnt;
    logic          head_bad;
    logic          drop;
    logic          cap_result;
    logic          cap_ovf;
    logic          busy;
    logic          ovf_sticky;
    logic          drop_err;
    logic          op_err;
    logic          result_valid;

    assign wr_rise    = hps_wr & ~wr_prev;
    assign ready_rise = cu_ready & ~ready_prev;

    assign fifo_pop   = (state == ST_IDLE) & ~fifo_empty;
    assign fifo_push  = wr_rise & (~fifo_full | fifo_pop);
    assign drop       = wr_rise & fifo_full & ~fifo_pop;
    assign head_bad   = instr_opcode(fifo_dout) > MAX_OPCODE;

    assign cap_result = (state == ST_CAPTURE) &
                        (instr_opcode(cu_instruction) == OPC_LOAD_MATRIXR);
    assign cap_ovf    = (state == ST_CAPTURE) & cu_overflow &
                        (instr_opcode(cu_instruction) <= OVF_OPCODE_MAX);

    assign busy       = (state != ST_IDLE) | ~fifo_empty;
    assign hps_status = {4'(fifo_count), busy, result_valid, drop_err | op_err, ovf_sticky};

    instr_dispatch_bridge_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (hps_instr & ~32'd1),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            wr_prev        <= 1'b0;
            ready_prev     <= 1'b0;
            wait_cnt       <= '0;
            cu_instruction <= '0;
            hps_result     <= '0;
            ovf_sticky     <= 1'b0;
            drop_err       <= 1'b0;
            op_err         <= 1'b0;
            result_valid   <= 1'b0;
        end else begin
            wr_prev    <= hps_wr;
            ready_prev <= cu_ready;

            unique case (state)
                ST_IDLE: begin
                    if (fifo_pop && !head_bad) begin
                        cu_instruction <= fifo_dout | 32'd1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cu_instruction[START_BIT] <= 1'b0;
                    wait_cnt                  <= WW'(CU_LATENCY);
                    state                     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Leaving when the count is 1 makes WAIT last exactly CU_LATENCY cycles.
                    wait_cnt <= wait_cnt - WW'(1);
                    if (ready_rise || wait_cnt <= WW'(1)) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (cap_result) hps_result <= cu_data;

            // A same-cycle set beats the HPS clear.
            ovf_sticky   <= cap_ovf | (ovf_sticky & ~hps_clr);
            result_valid <= cap_result | (result_valid & ~hps_clr);
            drop_err     <= drop | (drop_err & ~hps_clr);
            op_err       <= (fifo_pop & head_bad) | (op_err & ~hps_clr);
        end
    end

endmodule

// File: tb/tb_instr_dispatch_bridge.sv
// Self-checking bench for instr_dispatch_bridge: vector table plus directed
// sequences for overflow of the queue, clear/set collisions, early ready and reset.
`timescale 1ns/1ps
module tb_instr_dispatch_bridge;
    import instr_dispatch_bridge_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CU_LATENCY = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] hps_instr = '0;
    logic        hps_wr = 1'b0;
    logic        hps_clr = 1'b0;
    logic [31:0] hps_result;
    logic [7:0]  hps_status;
    logic [31:0] cu_instruction;
    logic        cu_ready = 1'b0;
    logic [31:0] cu_data = '0;
    logic        cu_overflow = 1'b0;

    instr_dispatch_bridge #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CU_LATENCY (CU_LATENCY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hps_instr      (hps_instr),
        .hps_wr         (hps_wr),
        .hps_clr        (hps_clr),
        .hps_result     (hps_result),
        .hps_status     (hps_status),
        .cu_instruction (cu_instruction),
        .cu_ready       (cu_ready),
        .cu_data        (cu_data),
        .cu_overflow    (cu_overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q[$];
    logic        start_prev = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
        logic        ovf;
        logic        clr;
        logic        exp_issue;
        logic        exp_rv;
        logic [31:0] exp_res;
        logic        exp_ovf;
        logic        exp_err;
    } vec_t;

    vec_t tv [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mk_instr(input logic [15:0] d, input logic [3:0] opc,
                                             input logic [1:0] ms, input logic [3:0] pos,
                                             input logic st);
        logic [31:0] w;
        w = '0;
        w[DATA_MSB:DATA_LSB]   = d;
        w[OPC_MSB:OPC_LSB]     = opc;
        w[MSIZE_MSB:MSIZE_LSB] = ms;
        w[POS_MSB:POS_LSB]     = pos;
        w[START_BIT]           = st;
        return w;
    endfunction

    function automatic vec_t mk_vec(input logic [31:0] instr, input logic [31:0] data,
                                    input logic ovf, input logic clr, input logic iss,
                                    input logic rv, input logic [31:0] res,
                                    input logic eovf, input logic eerr);
        vec_t v;
        v.instr = instr; v.data = data; v.ovf = ovf; v.clr = clr; v.exp_issue = iss;
        v.exp_rv = rv; v.exp_res = res; v.exp_ovf = eovf; v.exp_err = eerr;
        return v;
    endfunction

    function automatic logic [31:0] issued(input logic [31:0] w);
        return {w[31:1], 1'b1};
    endfunction

    function automatic logic [31:0] held(input logic [31:0] w);
        return {w[31:1], 1'b0};
    endfunction

    // Scoreboard consumer: every start pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && cu_instruction[START_BIT]) begin
            check("start_one_cycle", {31'd0, start_prev}, 32'd0);
            if (exp_q.size() == 0) check("unexpected_issue", cu_instruction, 32'd0);
            else check("issue_word", cu_instruction, exp_q.pop_front());
        end
        start_prev = rst & cu_instruction[START_BIT];
    end

    task automatic pulse(input logic [31:0] w);
        @(posedge clk); #1 hps_instr = w; hps_wr = 1'b1;
        @(posedge clk); #1 hps_wr = 1'b0;
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1 hps_clr = 1'b1;
        @(posedge clk); #1 hps_clr = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int cycles;
        cycles = 0;
        while (hps_status[3] !== 1'b0) begin
            @(negedge clk);
            cycles++;
            if (cycles >= bound) begin
                checks++;
                $display("FAIL idle_timeout: still busy after %0d cycles, required idle", bound);
                return;
            end
        end
    endtask

    task automatic wait_start(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (cu_instruction[START_BIT] === 1'b1) return;
        end
        checks++;
        $display("FAIL start_timeout: no start within %0d cycles, required one", bound);
    endtask

    initial begin
        logic [31:0] w;
        int n;
        int starts;

        tv[0]  = mk_vec(mk_instr(16'h0102, OPC_STORE_MATRIX1, 2'd0, 4'd0, 1'b0), 32'hCAFE0000,
                        1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tv[1]  = mk_vec(mk_instr(16'h0000, OPC_LOAD_MATRIXR, 2'd0, 4'd0, 1'b0), 32'hDEADBEEF,
                        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        tv[2]  = mk_vec(mk_instr(16'h00AA, OPC_SOMA, 2'd1, 4'd2, 1'b1), 32'hCAFE0002,
                        1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        tv[3]  = mk_vec(mk_instr(16'h5555, OPC_SUBTRACAO, 2'd2, 4'd3, 1'b0), 32'hCAFE0003,
                        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        tv[4]  = mk_vec(mk_instr(16'h0001, OPC_LOAD_MATRIXR, 2'd3, 4'd1, 1'b0), 32'h12345678,
                        1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0);
        tv[5]  = mk_vec(mk_instr(16'hFFFF, OPC_MULT_MATRIZ, 2'd1, 4'd15, 1'b0), 32'hCAFE0005,
                        1'b0, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0);
        tv[6]  = mk_vec(mk_instr(16'h1234, 4'b1111, 2'd0, 4'd0, 1'b0), 32'hCAFE0006,
                        1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b1);
        tv[7]  = mk_vec(mk_instr(16'h0F0F, OPC_SOMA, 2'd0, 4'd4, 1'b0), 32'hCAFE0007,
                        1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b1);
        tv[8]  = mk_vec(mk_instr(16'h00F0, OPC_DETERMINANTE, 2'd2, 4'd0, 1'b0), 32'hCAFE0008,
                        1'b1, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0);
        tv[9]  = mk_vec(mk_instr(16'h0A0A, OPC_STORE_MATRIX1, 2'd2, 4'd6, 1'b0), 32'hCAFE0009,
                        1'b1, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0);
        tv[10] = mk_vec(mk_instr(16'h7777, 4'b1010, 2'd0, 4'd0, 1'b0), 32'hCAFE000A,
                        1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cu_instruction", cu_instruction, 32'h0);
        check("rst_status", {24'd0, hps_status}, 32'h0);
        check("rst_result", hps_result, 32'h0);
        rst = 1'b1;

        // Single zero SOMA word: one start cycle, busy for CU_LATENCY+3 cycles
        exp_q.push_back(issued(32'h0));
        pulse(32'h0);
        n = 0;
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cu_instruction[START_BIT] === 1'b1) starts++;
            if (hps_status[3] !== 1'b1) break;
            n++;
        end
        check("t1_busy_cycles", n, CU_LATENCY + 3);
        check("t1_start_count", starts, 1);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            if (tv[i].clr) clr_pulse();
            cu_data     = tv[i].data;
            cu_overflow = tv[i].ovf;
            if (tv[i].exp_issue) exp_q.push_back(issued(tv[i].instr));
            pulse(tv[i].instr);
            wait_idle(40);
            @(negedge clk);
            check($sformatf("tv%0d_status", i), {24'd0, hps_status},
                  {24'd0, 4'd0, 1'b0, tv[i].exp_rv, tv[i].exp_err, tv[i].exp_ovf});
            check($sformatf("tv%0d_result", i), hps_result, tv[i].exp_res);
            check($sformatf("tv%0d_sb_drain", i), exp_q.size(), 0);
        end

        // Queue overflow: first word in flight, next four queued, the last dropped
        clr_pulse();
        cu_overflow = 1'b0;
        for (int i = 0; i < 7; i++) begin
            w = mk_instr(16'(i * 16 + 1), OPC_SOMA, 2'd1, 4'(i), 1'b0);
            if (i < 6) exp_q.push_back(issued(w));
            pulse(w);
        end
        @(negedge clk);
        check("drop_fifo_count", {28'd0, hps_status[7:4]}, FIFO_DEPTH);
        check("drop_err_flag", {31'd0, hps_status[1]}, 32'd1);
        wait_idle(300);
        check("drop_sb_drain", exp_q.size(), 0);

        // Clear coinciding with an overflow capture: the set wins
        clr_pulse();
        cu_overflow = 1'b1;
        w = mk_instr(16'h0C0C, OPC_SOMA, 2'd0, 4'd0, 1'b0);
        exp_q.push_back(issued(w));
        pulse(w);
        wait_start(20);
        repeat (6) @(posedge clk);
        #1 hps_clr = 1'b1;
        @(posedge clk);
        #1 hps_clr = 1'b0;
        @(negedge clk);
        check("clr_vs_set_ovf", {31'd0, hps_status[0]}, 32'd1);
        wait_idle(40);
        cu_overflow = 1'b0;

        // cu_ready rising edge ends WAIT early; word stays held meanwhile
        w = mk_instr(16'hBEEF, OPC_MULT_ESCALAR, 2'd2, 4'd5, 1'b0);
        exp_q.push_back(issued(w));
        pulse(w);
        wait_start(20);
        @(posedge clk);
        @(posedge clk);
        #1 cu_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (hps_status[3] !== 1'b1) break;
            check("ready_hold_word", cu_instruction, held(w));
        end
        check("ready_early_cycles", n, 3);
        cu_ready = 1'b0;

        // Asynchronous reset while the first word waits; the queued one is lost
        w = mk_instr(16'hFFFF, OPC_OPOSTA, 2'd3, 4'd9, 1'b0);
        exp_q.push_back(issued(w));
        pulse(w);
        pulse(mk_instr(16'h3333, OPC_SOMA, 2'd1, 4'd1, 1'b0));
        #2 rst = 1'b0;
        #1;
        check("async_rst_cu_instruction", cu_instruction, 32'h0);
        check("async_rst_status", {24'd0, hps_status}, 32'h0);
        check("async_rst_result", hps_result, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_status", {24'd0, hps_status}, 32'h0);
        repeat (12) @(negedge clk);
        check("post_rst_no_issue", cu_instruction, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
